// File: rtl/port_rx_capture.sv
// Receive stage for PIC32 byte writes: synchronizes port_e and the toggle tag,
// waits a settle interval, samples the byte into a FIFO and returns an ack tag.
module port_rx_capture #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         port_e,
  input  logic                          tag_in,
  output logic                          ack_tag,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [LVL_W-1:0] LEVEL_FULL   = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_sync_reg [SYNC_STAGES];
  logic                  tag_sync_reg  [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] data_s;
  logic                  tag_s;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          data_sync_reg[gi] <= '0;
          tag_sync_reg[gi]  <= 1'b0;
        end else begin
          data_sync_reg[gi] <= port_e;
          tag_sync_reg[gi]  <= tag_in;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          data_sync_reg[gi] <= '0;
          tag_sync_reg[gi]  <= 1'b0;
        end else begin
          data_sync_reg[gi] <= data_sync_reg[gi-1];
          tag_sync_reg[gi]  <= tag_sync_reg[gi-1];
        end
      end
    end
  end

  assign data_s = data_sync_reg[SYNC_STAGES-1];
  assign tag_s  = tag_sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_PUSH   = 2'd2
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              pend_tag_reg;
  logic              ack_tag_reg;

  logic [LVL_W-1:0]  level_reg;
  logic              fifo_full;
  logic              push_en;
  logic              pop_en;

  assign fifo_full = (level_reg == LEVEL_FULL);
  // Full is judged on the registered level, so a pop in the same cycle
  // does not free the slot until the next clock.
  assign push_en   = (state_reg == S_PUSH) && !fifo_full;
  assign pop_en    = out_ready && (level_reg != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      pend_tag_reg <= 1'b0;
      ack_tag_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (tag_s != ack_tag_reg) begin
            pend_tag_reg <= tag_s;
            cnt_reg      <= SETTLE_LOAD;
            state_reg    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg <= S_PUSH;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        S_PUSH: begin
          if (!fifo_full) begin
            ack_tag_reg <= pend_tag_reg;
            state_reg   <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ack_tag = ack_tag_reg;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= data_s;
    end
  end

  assign out_valid  = (level_reg != '0);
  assign out_data   = out_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_port_rx_capture.sv
// Self-checking bench for port_rx_capture: directed scenarios plus a randomized
// stream compared against an expected-byte queue.
module tb_port_rx_capture;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] port_e;
  logic          tag_in;
  logic          ack_tag;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    fifo_level;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] popped [$];
  logic [DW-1:0] exp_q  [$];
  int            max_level;
  bit            rand_ready;

  port_rx_capture #(
    .DATA_WIDTH   (DW),
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(2),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .port_e    (port_e),
    .tag_in    (tag_in),
    .ack_tag   (ack_tag),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_level(fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Consumer monitor: records the head whenever a pop will occur at the next edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && out_ready) popped.push_back(out_data);
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic tag_val);
    reset_n   = 1'b0;
    tag_in    = tag_val;
    out_ready = 1'b0;
    port_e    = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    popped.delete();
    exp_q.delete();
    max_level = 0;
    tick();
  endtask

  // PIC32-side transfer: present data, toggle tag, wait for the ack to match.
  task automatic send_byte(input logic [DW-1:0] b);
    int k;
    port_e = b;
    tick();
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    tag_in = ~tag_in;
    k = 0;
    while (ack_tag !== tag_in && k < 80) begin
      tick();
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      k++;
    end
    n_cmp++;
    if (ack_tag !== tag_in) begin
      n_fail++;
      $display("FAIL ack_timeout byte=%02h: ack_tag=%b required %b", b, ack_tag, tag_in);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    tag_in    = 1'b0;
    port_e    = 8'hFF;
    out_ready = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_cmp++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
    n_cmp++;
    if (ack_tag !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0", ack_tag); end
    n_cmp++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h required 00", out_data); end
    reset_n = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if ({out_valid, ack_tag, fifo_level} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_quiet: valid=%b ack=%b level=%0d required all 0", out_valid, ack_tag, fifo_level);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    do_reset(1'b0);
    port_e = 8'h5A;
    tag_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) begin
        n_cmp++;
        if ({out_valid, ack_tag, fifo_level} !== 5'd0) begin
          n_fail++;
          $display("FAIL single_early edge=%0d: valid=%b ack=%b level=%0d required 0/0/0",
                   k, out_valid, ack_tag, fifo_level);
        end
      end else begin
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b required 1", out_valid); end
        n_cmp++;
        if (out_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %02h required 5a", out_data); end
        n_cmp++;
        if (ack_tag !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b required 1", ack_tag); end
        n_cmp++;
        if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d required 1", fifo_level); end
      end
    end
    $display("test_single_byte done");
  endtask

  task automatic test_fill_backpressure();
    int k;
    do_reset(1'b0);
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    n_cmp++;
    if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fill_level4: got %0d required 4", fifo_level); end
    port_e = 8'h05;
    tick();
    tag_in = ~tag_in;
    repeat (15) tick();
    n_cmp++;
    if (ack_tag !== ~tag_in) begin n_fail++; $display("FAIL fill_ack_held: got %b required %b", ack_tag, ~tag_in); end
    n_cmp++;
    if (fifo_level !== 3'd4 || out_data !== 8'h01) begin
      n_fail++;
      $display("FAIL fill_full_head: level=%0d data=%02h required 4/01", fifo_level, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd3 || out_data !== 8'h02 || ack_tag !== ~tag_in) begin
      n_fail++;
      $display("FAIL fill_after_pop: level=%0d data=%02h ack=%b required 3/02/%b",
               fifo_level, out_data, ack_tag, ~tag_in);
    end
    tick();
    n_cmp++;
    if (fifo_level !== 3'd4 || ack_tag !== tag_in) begin
      n_fail++;
      $display("FAIL fill_late_push: level=%0d ack=%b required 4/%b", fifo_level, ack_tag, tag_in);
    end
    out_ready = 1'b1;
    k = 0;
    while (out_valid === 1'b1 && k < 20) begin tick(); k++; end
    out_ready = 1'b0;
    tick();
    for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
    n_cmp++;
    if (popped.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL fill_count: got %0d bytes required %0d", popped.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [DW-1:0] got;
      got = (i < popped.size()) ? popped[i] : 8'hxx;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL fill_order[%0d]: got %02h required %02h", i, got, exp_q[i]); end
    end
    $display("test_fill_backpressure done");
  endtask

  task automatic test_ordering_wrap();
    do_reset(1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      send_byte(8'(8'h10 + i));
    end
    repeat (5) tick();
    out_ready = 1'b0;
    n_cmp++;
    if (popped.size() != 10) begin n_fail++; $display("FAIL wrap_count: got %0d required 10", popped.size()); end
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] got;
      got = (i < popped.size()) ? popped[i] : 8'hxx;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %02h required %02h", i, got, exp_q[i]); end
    end
    n_cmp++;
    if (max_level > 1) begin n_fail++; $display("FAIL wrap_max_level: got %0d required <=1", max_level); end
    $display("test_ordering_wrap done");
  endtask

  task automatic test_push_pop();
    do_reset(1'b0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    n_cmp++;
    if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL pp_level2: got %0d required 2", fifo_level); end
    port_e = 8'hA3;
    tick();
    tag_in = ~tag_in;
    repeat (5) tick();
    n_cmp++;
    if (fifo_level !== 3'd2 || ack_tag === tag_in) begin
      n_fail++;
      $display("FAIL pp_before: level=%0d ack=%b required 2/%b", fifo_level, ack_tag, ~tag_in);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd2 || out_data !== 8'hA2 || ack_tag !== tag_in) begin
      n_fail++;
      $display("FAIL pp_same_cycle: level=%0d data=%02h ack=%b required 2/a2/%b",
               fifo_level, out_data, ack_tag, tag_in);
    end
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    n_cmp++;
    if (popped.size() != 3) begin n_fail++; $display("FAIL pp_count: got %0d required 3", popped.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] got;
      got = (i < popped.size()) ? popped[i] : 8'hxx;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL pp_order[%0d]: got %02h required %02h", i, got, exp_q[i]); end
    end
    $display("test_push_pop done");
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    n_cmp++;
    if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL rm_level3: got %0d required 3", fifo_level); end
    port_e = 8'h77;
    tick();
    tag_in = ~tag_in;
    repeat (3) tick();
    reset_n = 1'b0;
    #2;
    n_cmp++;
    if ({out_valid, ack_tag, fifo_level} !== 5'd0) begin
      n_fail++;
      $display("FAIL rm_async: valid=%b ack=%b level=%0d required 0/0/0", out_valid, ack_tag, fifo_level);
    end
    tag_in = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    n_cmp++;
    if ({out_valid, ack_tag, fifo_level} !== 5'd0) begin
      n_fail++;
      $display("FAIL rm_after: valid=%b ack=%b level=%0d required 0/0/0", out_valid, ack_tag, fifo_level);
    end
    popped.delete();
    send_byte(8'hC3);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    n_cmp++;
    if (popped.size() != 1) begin n_fail++; $display("FAIL rm_count: got %0d required 1", popped.size()); end
    n_cmp++;
    if (popped.size() < 1 || popped[0] !== 8'hC3) begin
      n_fail++;
      $display("FAIL rm_byte: got %02h required c3", (popped.size() > 0) ? popped[0] : 8'hxx);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_data_change_settle();
    int k;
    do_reset(1'b0);
    port_e = 8'h11;
    tick();
    tag_in = 1'b1;
    tick();
    port_e = 8'h22;
    k = 0;
    while (ack_tag !== tag_in && k < 20) begin tick(); k++; end
    n_cmp++;
    if (out_data !== 8'h22 || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL settle_data: data=%02h level=%0d required 22/1", out_data, fifo_level);
    end
    $display("test_data_change_settle done");
  endtask

  task automatic test_tag_violation();
    do_reset(1'b0);
    port_e = 8'h44;
    tag_in = 1'b1;
    tick();
    tag_in = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if (fifo_level !== 3'd2 || ack_tag !== 1'b0) begin
      n_fail++;
      $display("FAIL violation: level=%0d ack=%b required 2/0", fifo_level, ack_tag);
    end
    $display("test_tag_violation done");
  endtask

  task automatic test_tag_high_reset();
    int k;
    do_reset(1'b1);
    k = 0;
    while (ack_tag !== 1'b1 && k < 20) begin tick(); k++; end
    n_cmp++;
    if (ack_tag !== 1'b1 || fifo_level !== 3'd1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL tag_high_reset: ack=%b level=%0d valid=%b required 1/1/1", ack_tag, fifo_level, out_valid);
    end
    $display("test_tag_high_reset done");
  endtask

  task automatic test_random();
    logic [DW-1:0] b;
    do_reset(1'b0);
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b);
      repeat ($urandom_range(0, 3)) begin
        tick();
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (10) tick();
    out_ready = 1'b0;
    tick();
    n_cmp++;
    if (popped.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d required %0d", popped.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [DW-1:0] got;
      got = (i < popped.size()) ? popped[i] : 8'hxx;
      n_cmp++;
      if (got !== exp_q[i]) begin n_fail++; $display("FAIL rand_order[%0d]: got %02h required %02h", i, got, exp_q[i]); end
    end
    n_cmp++;
    if (max_level > DEPTH) begin n_fail++; $display("FAIL rand_max_level: got %0d required <=%0d", max_level, DEPTH); end
    $display("test_random done (%0d bytes)", exp_q.size());
  endtask

  initial begin
    reset_n    = 1'b0;
    port_e     = '0;
    tag_in     = 1'b0;
    out_ready  = 1'b0;
    rand_ready = 1'b0;
    max_level  = 0;
    test_reset();
    test_single_byte();
    test_fill_backpressure();
    test_ordering_wrap();
    test_push_pop();
    test_reset_mid();
    test_data_change_settle();
    test_tag_violation();
    test_tag_high_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/port_rx_capture.md
Name: port_rx_capture

Overview:
- Upstream input stage for the FPGA coprocessor core. Receives bytes written by the PIC32 on port_e, framed by a toggle-tag on port_d_in[7].
- Synchronizes the asynchronous port pins and waits a settle interval before sampling the byte.
- Buffers the byte in a small FIFO that the compute state machine drains with a valid/ready handshake.
- Returns an acknowledge tag to the PIC32, which provides back-pressure when the FIFO is full.

Parameters:
DATA_WIDTH, 8, width of port_e and of the FIFO entries
SYNC_STAGES, 2, synchronizer flops on port_e and tag (≥2)
SETTLE_CYCLES, 2, extra clocks between tag detection and data sampling (≥1)
FIFO_DEPTH, 4, FIFO entries (power of 2, ≥2)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset (driven from port_d_in[5])
port_e  input  DATA_WIDTH  asynchronous data pins from the PIC32
tag_in  input  1  asynchronous toggle-tag pin (port_d_in[7]); each level change announces a new byte
ack_tag  output  1  tag value of the last byte accepted into the FIFO; routed to port_d_out[0]
out_data  output  DATA_WIDTH  FIFO head
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer pops the head when out_valid & out_ready at a clock edge
fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, named reset_n; clock port named clock.
- Reset values:
  - all synchronizer flops 0; ack_tag=0;
  - FSM=IDLE; settle counter 0;
  - FIFO pointers 0, fifo_level=0, out_valid=0, out_data=0.
- Synchronizers:
  - port_e and tag_in each pass through SYNC_STAGES flops, giving data_s and tag_s.
  - No other logic samples the raw pins.
- FSM:
  - IDLE: if tag_s != ack_tag, latch pend_tag<=tag_s, counter<=SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: if counter==0 go to PUSH; else decrement the counter.
  - PUSH: if fifo_level<FIFO_DEPTH (registered value, start of cycle):
    - write data_s at the write pointer;
    - ack_tag<=pend_tag;
    - go to IDLE.
    Otherwise stay in PUSH; data_s keeps being resampled until the write happens.
- Latency: count the first clock edge that samples the new tag_in level as edge 1. With an empty FIFO, out_valid and the ack_tag toggle both appear after edge SYNC_STAGES+SETTLE_CYCLES+2. With defaults this is edge 6.
- Protocol (PIC32 side):
  - set port_e, then toggle tag_in;
  - hold port_e until ack_tag == tag_in;
  - only then send the next byte.
- FIFO:
  - out_data is the head entry, combinational from storage; out_valid = (fifo_level != 0).
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Full with a simultaneous pop: no push that cycle. PUSH writes on the next cycle (no full-bypass).
  - Empty with a simultaneous push: no bypass. out_valid rises the cycle after the write.
  - Pop while empty is ignored; level never underflows.
  - When empty, out_data is don't-care and the bench must not check it.
- Tag toggles again before ack (protocol violation): pend_tag is already latched, so one byte is pushed and ack_tag=pend_tag. If tag_s still differs afterwards, a further transfer starts. No lockup; byte content is unspecified.
- tag_in high at reset release: treated as a pending transfer. One byte is captured and ack_tag becomes 1.
- Reset mid-transfer: any state returns to reset values immediately and FIFO contents are discarded.

Test Plan:
- Single byte: reset, port_e=0x5A, toggle tag_in 0→1, out_ready=0 -> out_valid=1, out_data=0x5A, ack_tag=1, fifo_level=1 at edge 6; none of these earlier.
- Fill/back-pressure: send 0x01..0x05 following the ack protocol with out_ready=0 -> fifo_level=4, ack_tag stops after the 4th byte, FSM holds in PUSH. Then assert out_ready for one cycle -> 0x01 popped, 0x05 written the following cycle, ack_tag toggles.
- Ordering and wrap: stream 10 bytes 0x10..0x19 with out_ready=1 continuously -> output sequence exactly 0x10..0x19, fifo_level never >1 beyond transients, no loss or duplication across pointer wrap.
- Simultaneous push/pop at level 2 -> level stays 2, head advances, new byte is appended at the tail.
- Reset mid-SETTLE and with FIFO at level 3 -> after the reset_n low pulse: out_valid=0, fifo_level=0, ack_tag=0. A later tag toggle with port_e=0xC3 delivers 0xC3 as the only output.
- Data change during SETTLE: port_e changes 0x11→0x22 one clock after the tag toggle -> captured byte is 0x22, because sampling happens in PUSH.
